// File: rtl/param_sync_counter.sv
// Parametrised synchronous up/down counter with modulus, parallel load, wrap or
// saturate ends, combinational terminal count for cascading, and registered pulses.
module param_sync_counter #(
    parameter int     WIDTH       = 4,
    parameter longint MODULUS     = 10,
    parameter bit     SATURATE    = 1'b0,
    parameter longint RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped,
    output logic             load_err
);

    // One extra bit so MODULUS == 2^WIDTH is representable for the load range check.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrapped_q, wrapped_d;
    logic             load_err_q, load_err_d;
    logic             at_max, at_min;

    assign at_max = (q_q == MAX_V);
    assign at_min = (q_q == '0);

    always_comb begin
        q_d        = q_q;
        wrapped_d  = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                q_d = load_val;
            end else begin
                q_d        = MAX_V;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q_d = q_q + ONE;
                end else if (!SATURATE) begin
                    q_d       = '0;
                    wrapped_d = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    q_d = q_q - ONE;
                end else if (!SATURATE) begin
                    q_d       = MAX_V;
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q        <= RST_V;
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end

    // Asserted at the range end even when saturating, so cascades stay aligned.
    assign tc       = en & ~load & ~clear & ((up & at_max) | (~up & at_min));
    assign q        = q_q;
    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_param_sync_counter.sv
// Scoreboard bench: three single counters (decade wrap, decade saturate, binary 16)
// plus a two-stage decade cascade, all checked against an arithmetic model.
module tb_param_sync_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear, en, up, load, en_c;
    logic [3:0] load_val;
    logic [3:0] q0, q1, q2, cq0, cq1;
    logic       tc0, tc1, tc2, w0, w1, w2, le0, le1, le2;
    logic       ctc0, ctc1, cw0, cw1, cle0, cle1;

    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VALUE(0)) u_dec (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q0), .tc(tc0), .wrapped(w0), .load_err(le0));
    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q1), .tc(tc1), .wrapped(w1), .load_err(le1));
    param_sync_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VALUE(0)) u_bin (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q2), .tc(tc2), .wrapped(w2), .load_err(le2));
    param_sync_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (
        .clk(clk), .clear(clear), .en(en_c), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .q(cq0), .tc(ctc0), .wrapped(cw0), .load_err(cle0));
    param_sync_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
        .clk(clk), .clear(clear), .en(ctc0), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .q(cq1), .tc(ctc1), .wrapped(cw1), .load_err(cle1));

    typedef struct packed {
        logic [2:0][4:0] q;
        logic [2:0]      w;
        logic [2:0]      le;
        logic [6:0]      cnt;
        logic            cw0;
        logic            cw1;
    } st_t;
    typedef struct packed {
        logic [2:0] tc;
        logic       ctc0;
        logic       ctc1;
    } tc_t;

    st_t sq[$];
    tc_t tq[$];
    int  errors = 0;
    int  checks = 0;
    int  m[3];
    int  cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: modulo arithmetic on plain integers, applied to each counter.
    task automatic cyc(input bit c, input bit l, input bit e, input bit u, input int lv);
        st_t s;
        tc_t t;
        int  md, nq;
        bit  sat, w, le;
        @(negedge clk);
        clear = c; load = l; en = e; up = u; load_val = 4'(lv);
        for (int i = 0; i < 3; i++) begin
            md  = (i == 2) ? 16 : 10;
            sat = (i == 1);
            nq  = m[i];
            w   = 1'b0;
            le  = 1'b0;
            t.tc[i] = e && !l && !c && ((u && m[i] == md - 1) || (!u && m[i] == 0));
            if (c) nq = 0;
            else if (l) begin
                if (lv < md) nq = lv;
                else begin nq = md - 1; le = 1'b1; end
            end else if (e) begin
                if (u && (m[i] < md - 1 || !sat)) begin nq = (m[i] + 1) % md; w = (m[i] == md - 1); end
                if (!u && (m[i] > 0 || !sat)) begin nq = (m[i] + md - 1) % md; w = (m[i] == 0); end
            end
            s.q[i]  = 5'(nq);
            s.w[i]  = w;
            s.le[i] = le;
            m[i]    = nq;
        end
        t.ctc0 = !c && (cnt % 10 == 9);
        t.ctc1 = t.ctc0 && (cnt / 10 == 9);
        s.cw0  = t.ctc0;
        s.cw1  = t.ctc1;
        cnt    = c ? 0 : (cnt + 1) % 100;
        s.cnt  = 7'(cnt);
        tq.push_back(t);
        sq.push_back(s);
    endtask

    initial begin : monitor
        tc_t t;
        st_t s;
        forever begin
            @(negedge clk); #1;
            if (tq.size() > 0) begin
                t = tq.pop_front();
                chk("tc_dec", tc0, t.tc[0]);
                chk("tc_sat", tc1, t.tc[1]);
                chk("tc_bin", tc2, t.tc[2]);
                chk("tc_c0", ctc0, t.ctc0);
                chk("tc_c1", ctc1, t.ctc1);
            end
            @(posedge clk); #1;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("q_dec", q0, s.q[0]);
                chk("q_sat", q1, s.q[1]);
                chk("q_bin", q2, s.q[2]);
                chk("wrap_dec", w0, s.w[0]);
                chk("wrap_sat", w1, s.w[1]);
                chk("wrap_bin", w2, s.w[2]);
                chk("lerr_dec", le0, s.le[0]);
                chk("lerr_sat", le1, s.le[1]);
                chk("lerr_bin", le2, s.le[2]);
                chk("casc_val", cq1 * 10 + cq0, s.cnt);
                chk("casc_wrap0", cw0, s.cw0);
                chk("casc_wrap1", cw1, s.cw1);
                chk("casc_lerr", {cle1, cle0}, 0);
            end
        end
    end

    initial begin
        clear = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 4'd0; en_c = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) m[i] = 0;
        repeat (2) @(posedge clk);
        cyc(1, 0, 0, 1, 0);                       // reset state
        repeat (12) cyc(0, 0, 1, 1, 0);           // decade wrap
        cyc(0, 1, 1, 1, 3);                       // load beats en
        repeat (5) cyc(0, 0, 1, 0, 0);            // down wrap
        cyc(1, 1, 0, 1, 5);                       // clear beats load
        cyc(0, 1, 0, 1, 8);
        repeat (4) cyc(0, 0, 1, 1, 0);            // saturate high
        repeat (10) cyc(0, 0, 1, 0, 0);           // saturate low
        cyc(0, 1, 0, 1, 12);                      // clamp
        cyc(0, 1, 0, 1, 7);
        repeat (3) cyc(0, 0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);            // hold with en low
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (105) cyc(0, 0, 1, 1, 0);          // cascade 00..99..00, binary rollover
        repeat (400)
            cyc(($urandom % 40) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                $urandom % 2 == 1, int'($urandom % 16));
        for (int k = 0; k < 10 && (sq.size() != 0 || tq.size() != 0); k++) @(negedge clk);
        if (sq.size() != 0 || tq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sq.size() + tq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
